gate_sweep_ctrl: RTL

Sweep sequencer and self-checker for the 3-input gate datapath, where x = (A&B)|~C and y = ~C.
- Drives every input vector ABC = 0..7 onto the datapath in order.
- Waits a programmable settle time, samples x/y, and compares them against an internal golden model.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits beside the gate datapath in the project top. It can run one sweep or run continuously as a built-in self-test.

---
 rtl/gate_sweep_pkg.sv | 27 ++
 rtl/gate_golden_model.sv | 12 +
 rtl/gate_sweep_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate datapath sweep checker: widths, FSM encoding
// and the golden function of the 3-input gate, x = (A&B)|~C, y = ~C.
package gate_sweep_pkg;

  localparam int VEC_W = 3;
  localparam int RES_W = 2;

  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_e;

  // vec = {C, B, A}; result = {y, x}
  function automatic logic [RES_W-1:0] golden_res(input logic [VEC_W-1:0] vec);
    logic x;
    logic y;
    y = ~vec[2];
    x = (vec[0] & vec[1]) | y;
    return {y, x};
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for the gate datapath; the sweep controller compares
// the real datapath result against this in its SAMPLE cycle.
module gate_golden_model
  import gate_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [RES_W-1:0] exp_res_o
);

  assign exp_res_o = golden_res(vec_i);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweep sequencer and self-checker: walks ABC = 0..7 across the gate datapath,
// waits SETTLE_CYCLES, samples x/y and accumulates pass/fail information.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int SETTLE_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  input  logic [RES_W-1:0] res_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15 || (2 ** SETTLE_W) <= SETTLE_CYCLES) begin : g_param_check
    $error("gate_sweep_ctrl: SETTLE_CYCLES must be 0..15 and fit in SETTLE_W bits");
  end

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] APPLY  = ST_APPLY;
  localparam logic [2:0] SETTLE = ST_SETTLE;
  localparam logic [2:0] SAMPLE = ST_SAMPLE;
  localparam logic [2:0] DONE   = ST_DONE;

  // Terminal settle count; unreachable when SETTLE_CYCLES is 0 because APPLY skips SETTLE.
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [2:0]          state_q,     state_d;
  logic [VEC_W-1:0]    vec_q,       vec_d;
  logic [SETTLE_W-1:0] settle_q,    settle_d;
  logic [3:0]          err_q,       err_d;
  logic [VEC_W-1:0]    ff_vec_q,    ff_vec_d;
  logic                ff_valid_q,  ff_valid_d;
  logic                pass_q,      pass_d;
  logic                vec_valid_q, vec_valid_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  logic [RES_W-1:0]    exp_res;
  logic                mismatch;

  gate_golden_model u_golden (
    .vec_i     (vec_q),
    .exp_res_o (exp_res)
  );

  assign mismatch = (res_in != exp_res);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    err_d      = err_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    pass_d     = pass_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = APPLY;
          vec_d      = '0;
          err_d      = '0;
          pass_d     = 1'b0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
        end
      end

      APPLY: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (!ff_valid_q) begin
            ff_vec_d   = vec_q;
            ff_valid_d = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
          // Uses err_d so the last vector's compare is part of the verdict.
          pass_d  = (err_d == 4'd0);
        end else begin
          vec_d   = vec_q + 3'd1;
          state_d = APPLY;
        end
      end

      DONE: begin
        if (cont) begin
          state_d    = APPLY;
          vec_d      = '0;
          err_d      = '0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
          vec_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        vec_d   = '0;
      end
    endcase

    // Abort overrides whatever the state decided, but keeps the error record.
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      vec_d      = '0;
      pass_d     = 1'b0;
      err_d      = err_q;
      ff_vec_d   = ff_vec_q;
      ff_valid_d = ff_valid_q;
    end

    vec_valid_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == SAMPLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: all state here is a handful of control flops with defined reset
      // values; nothing is memory-like, so everything is reset.
      state_q     <= IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      err_q       <= '0;
      ff_vec_q    <= '0;
      ff_valid_q  <= 1'b0;
      pass_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      ff_vec_q    <= ff_vec_d;
      ff_valid_q  <= ff_valid_d;
      pass_q      <= pass_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vec_out          = vec_q;
  assign vec_valid        = vec_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;

endmodule
